com_arb: RTL and testbench
==========================

Name: com_arb

Overview:
- Round-robin arbiter and sequencer that shares the com transmit path (fs_send/fd_send, send_btype, send_dlen, ram_addr_init) between NREQ independent requesters, e.g. data packer, status reporter and command echo.
- Sits in the sys_clk domain, directly upstream of com.
- Grants one requester at a time and latches its packet descriptor.
- Runs the fs/fd handshake with com, then returns completion to the granted requester.

Parameters:
- NREQ, 4, number of requesters (2..8).
- GID_W, 2, width of grant index, equal to clog2(NREQ).
- TO_W, 16, width of the watchdog counter (used only with the optional feature).

Ports:
- clk  in  1  system clock (sys_clk).
- rst  in  1  asynchronous, active-low reset.
- req_fs  in  NREQ  per-requester start flag; held high until the matching req_fd is seen.
- req_btype  in  NREQ*4  per-requester packet type; slice i = bits [4i+3:4i]; stable while req_fs[i]=1.
- req_dlen  in  NREQ*12  per-requester payload length in bytes.
- req_addr  in  NREQ*12  per-requester RAM start address.
- req_fd  out  NREQ  per-requester done flag.
- fs_send  out  1  start flag to com.
- send_btype  out  4  latched btype to com.
- send_dlen  out  12  latched dlen to com.
- ram_addr_init  out  12  latched address to com.
- fd_send  in  1  done flag from com.
- busy  out  1  high in every state except IDLE.
- grant_id  out  GID_W  index of the current or last granted requester.
- err_timeout  out  1  one-cycle pulse on watchdog abort; constant 0 without the optional feature.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, rr_ptr=0.
  - All outputs 0: fs_send, req_fd, send_btype, send_dlen, ram_addr_init, grant_id, busy, err_timeout.
  - Reset mid-transfer aborts immediately; com sees fs_send fall asynchronously.
- States: IDLE, GRANT, SEND, DONE.
- IDLE:
  - If any req_fs bit is high, pick the first set bit searching from rr_ptr upward with wrap (rr_ptr, rr_ptr+1, ..., NREQ-1, 0, ...).
  - Register the winner into grant_id and go to GRANT.
  - Only bits set in this cycle are considered.
- GRANT, one cycle:
  - Latch the winner's btype/dlen/addr slices into send_btype/send_dlen/ram_addr_init.
  - If the latched dlen is nonzero, go to SEND.
  - If dlen==0, go straight to DONE; fs_send is never raised.
- SEND:
  - fs_send=1.
  - On fd_send=1, drop fs_send on the next edge and go to DONE.
  - Grant-to-fs_send latency is 2 cycles from the IDLE detection edge.
- DONE:
  - req_fd[grant_id]=1; fs_send=0.
  - Exit to IDLE when req_fs[grant_id]=0 and fd_send=0, i.e. both handshakes fully closed.
  - On exit, req_fd clears, rr_ptr=grant_id+1 (wrap to 0 at NREQ), and busy falls.
- The descriptor outputs hold their last values after completion; only GRANT updates them.
- If the granted requester drops req_fs before its req_fd, this is a protocol violation. The arbiter ignores it: the transfer continues, and the DONE exit condition is already satisfied once fd_send=0.
- New or withdrawn requests during GRANT/SEND/DONE have no effect on the current transfer.
- At most one req_fd bit is high at any time.
- fd_send high in IDLE or GRANT is ignored.
- Fairness: every persistently asserted requester is granted within NREQ transfers.

Optional Feature:
- Macro: COM_ARB_TIMEOUT_EN.
- With the macro:
  - A TO_W-bit counter clears on entry to SEND and increments each SEND cycle.
  - If it reaches all-ones before fd_send arrives, fs_send drops, err_timeout pulses for 1 cycle, and the FSM goes to DONE.
  - In this aborted case, DONE exits on req_fs[grant_id]=0 alone, ignoring fd_send.
- Without the macro: no counter; SEND waits forever; err_timeout is tied 0.

Decomposition:
- Shared package com_pkg holds:
  - State enum constants ST_IDLE=2'd0, ST_GRANT=2'd1, ST_SEND=2'd2, ST_DONE=2'd3.
  - BTYPE_W=4, DLEN_W=12, ADDR_W=12.
  - The btype code constants already used by com_tx.
- One natural sub-module: com_arb_rr, a purely combinational rotate/priority-pick/rotate-back.
  - Inputs: req vector and rr_ptr.
  - Outputs: valid and index.
  - Instantiated once; verifiable standalone.

Test Plan:
- Single request: req_fs[1]=1, btype=4'h3, dlen=12'd64, addr=12'h100.
  - Expected: grant_id=1; fs_send rises 2 cycles later with send_btype=3, send_dlen=64, ram_addr_init=0x100.
  - fd_send pulse → req_fd[1]=1 → drop req_fs[1] → req_fd[1]=0 and busy=0.
- Round-robin: req_fs=4'b1111 held, each transfer completed.
  - Expected grant order 0,1,2,3,0; no requester is granted twice before all have been served.
- Zero length: req_fs[2]=1, dlen=0.
  - Expected: fs_send stays 0 throughout; req_fd[2] rises 2 cycles after grant.
- Late request: req_fs[3] raised while requester 0 is in SEND.
  - Expected: send_* values unchanged until the current transfer completes; requester 3 is granted next.
- Reset mid-SEND: rst=0 while fs_send=1.
  - Expected: all outputs 0 immediately; after release, state=IDLE and rr_ptr=0.
- COM_ARB_TIMEOUT_EN defined, TO_W=4, no fd_send.
  - Expected: fs_send drops after 15 SEND cycles, err_timeout pulses once, and req_fd of the granted requester asserts.

Source files
------------

// File: rtl/com_pkg.sv
// Shared definitions for the com transmit path.
// Covers FSM state codes, descriptor field widths and packet type codes.
package com_pkg;

   localparam int BTYPE_W = 4;
   localparam int DLEN_W  = 12;
   localparam int ADDR_W  = 12;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_SEND  = 2'd2,
      ST_DONE  = 2'd3
   } arb_state_t;

   // Packet type codes understood by com_tx.
   localparam logic [BTYPE_W-1:0] BTYPE_DATA   = 4'h1;
   localparam logic [BTYPE_W-1:0] BTYPE_STATUS = 4'h2;
   localparam logic [BTYPE_W-1:0] BTYPE_ECHO   = 4'h3;

endpackage

// File: rtl/com_arb_rr.sv
// Combinational round-robin pick.
// Rotates the request vector so rr_ptr sits at bit 0, takes the lowest set bit, then rotates the index back.
module com_arb_rr #(
   parameter int NREQ  = 4,
   parameter int GID_W = 2
) (
   input  logic [NREQ-1:0]  req,
   input  logic [GID_W-1:0] rr_ptr,
   output logic             valid,
   output logic [GID_W-1:0] index
);

   logic [NREQ-1:0]  req_rot;
   logic [GID_W-1:0] off;
   logic [GID_W:0]   sum;

   for (genvar gi = 0; gi < NREQ; gi++) begin : g_rot
      logic [GID_W:0]   pos;
      logic [GID_W-1:0] src;
      assign pos = {1'b0, rr_ptr} + (GID_W+1)'(gi);
      assign src = (pos >= (GID_W+1)'(NREQ)) ? GID_W'(pos - (GID_W+1)'(NREQ))
                                             : pos[GID_W-1:0];
      assign req_rot[gi] = req[src];
   end

   // Descending scan so the lowest rotated position wins.
   always_comb begin
      off = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (req_rot[k]) off = GID_W'(k);
      end
   end

   assign valid = |req;
   assign sum   = {1'b0, rr_ptr} + {1'b0, off};
   assign index = (sum >= (GID_W+1)'(NREQ)) ? GID_W'(sum - (GID_W+1)'(NREQ))
                                            : sum[GID_W-1:0];

endmodule

// File: rtl/com_arb.sv
// Round-robin arbiter sharing the com transmit path between NREQ requesters.
// Define COM_ARB_TIMEOUT_EN to add a SEND watchdog that aborts a transfer com never completes.
module com_arb
   import com_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int GID_W = 2,
   parameter int TO_W  = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req_fs,
   input  logic [NREQ*BTYPE_W-1:0] req_btype,
   input  logic [NREQ*DLEN_W-1:0]  req_dlen,
   input  logic [NREQ*ADDR_W-1:0]  req_addr,
   output logic [NREQ-1:0]         req_fd,
   output logic                    fs_send,
   output logic [BTYPE_W-1:0]      send_btype,
   output logic [DLEN_W-1:0]       send_dlen,
   output logic [ADDR_W-1:0]       ram_addr_init,
   input  logic                    fd_send,
   output logic                    busy,
   output logic [GID_W-1:0]        grant_id,
   output logic                    err_timeout
);

   if (NREQ < 2 || NREQ > 8 || GID_W != $clog2(NREQ) || TO_W < 2) begin : g_bad_param
      $error("com_arb: unsupported NREQ/GID_W/TO_W combination");
   end

   arb_state_t         state_reg, state_next;
   logic [GID_W-1:0]   grant_id_reg, grant_id_next;
   logic [GID_W-1:0]   rr_ptr_reg, rr_ptr_next;
   logic [BTYPE_W-1:0] btype_reg;
   logic [DLEN_W-1:0]  dlen_reg;
   logic [ADDR_W-1:0]  addr_reg;

   logic               pick_valid;
   logic [GID_W-1:0]   pick_index;
   logic [BTYPE_W-1:0] sel_btype;
   logic [DLEN_W-1:0]  sel_dlen;
   logic [ADDR_W-1:0]  sel_addr;
   logic               to_hit;
   logic               done_close;

   com_arb_rr #(
      .NREQ  (NREQ),
      .GID_W (GID_W)
   ) u_rr (
      .req    (req_fs),
      .rr_ptr (rr_ptr_reg),
      .valid  (pick_valid),
      .index  (pick_index)
   );

   assign sel_btype = req_btype[grant_id_reg*BTYPE_W +: BTYPE_W];
   assign sel_dlen  = req_dlen[grant_id_reg*DLEN_W +: DLEN_W];
   assign sel_addr  = req_addr[grant_id_reg*ADDR_W +: ADDR_W];

`ifdef COM_ARB_TIMEOUT_EN
   // Abort on the edge where the counter would reach all-ones.
   localparam logic [TO_W-1:0] TO_LAST = {TO_W{1'b1}} - TO_W'(1);

   logic [TO_W-1:0] to_cnt_reg;
   logic            aborted_reg;
   logic            err_reg;

   assign to_hit = (state_reg == ST_SEND) && !fd_send && (to_cnt_reg == TO_LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         to_cnt_reg  <= '0;
         aborted_reg <= 1'b0;
         err_reg     <= 1'b0;
      end else begin
         if (state_reg == ST_GRANT) to_cnt_reg <= '0;
         else if (state_reg == ST_SEND) to_cnt_reg <= to_cnt_reg + TO_W'(1);
         if (to_hit) aborted_reg <= 1'b1;
         else if (state_reg == ST_IDLE) aborted_reg <= 1'b0;
         err_reg <= to_hit;
      end
   end

   assign err_timeout = err_reg;
   // An aborted transfer must not wait on com, which may never answer.
   assign done_close  = !fd_send || aborted_reg;
`else
   assign to_hit      = 1'b0;
   assign err_timeout = 1'b0;
   assign done_close  = !fd_send;
`endif

   always_comb begin
      state_next    = state_reg;
      grant_id_next = grant_id_reg;
      rr_ptr_next   = rr_ptr_reg;
      case (state_reg)
         ST_IDLE: begin
            if (pick_valid) begin
               grant_id_next = pick_index;
               state_next    = ST_GRANT;
            end
         end
         ST_GRANT: state_next = (sel_dlen != '0) ? ST_SEND : ST_DONE;
         ST_SEND: begin
            if (fd_send || to_hit) state_next = ST_DONE;
         end
         ST_DONE: begin
            if (!req_fs[grant_id_reg] && done_close) begin
               state_next  = ST_IDLE;
               rr_ptr_next = (grant_id_reg == GID_W'(NREQ - 1)) ? '0
                                                               : grant_id_reg + GID_W'(1);
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg    <= ST_IDLE;
         grant_id_reg <= '0;
         rr_ptr_reg   <= '0;
         btype_reg    <= '0;
         dlen_reg     <= '0;
         addr_reg     <= '0;
      end else begin
         state_reg    <= state_next;
         grant_id_reg <= grant_id_next;
         rr_ptr_reg   <= rr_ptr_next;
         if (state_reg == ST_GRANT) begin
            btype_reg <= sel_btype;
            dlen_reg  <= sel_dlen;
            addr_reg  <= sel_addr;
         end
      end
   end

   // Handshake outputs decode straight from state so reset removes them without waiting for a clock.
   always_comb begin
      req_fd = '0;
      if (state_reg == ST_DONE) req_fd[grant_id_reg] = 1'b1;
   end

   assign fs_send       = (state_reg == ST_SEND);
   assign busy          = (state_reg != ST_IDLE);
   assign grant_id      = grant_id_reg;
   assign send_btype    = btype_reg;
   assign send_dlen     = dlen_reg;
   assign ram_addr_init = addr_reg;

endmodule

// File: tb/tb_com_arb.sv
// Directed bench for com_arb: table of single transfers plus hand-written round-robin, late-request,
// reset and (with COM_ARB_TIMEOUT_EN) watchdog sequences.
module tb_com_arb;

   logic        clk;
   logic        rst;
   logic [3:0]  req_fs;
   logic [15:0] req_btype;
   logic [47:0] req_dlen;
   logic [47:0] req_addr;
   logic [3:0]  req_fd;
   logic        fs_send;
   logic [3:0]  send_btype;
   logic [11:0] send_dlen;
   logic [11:0] ram_addr_init;
   logic        fd_send;
   logic        busy;
   logic [1:0]  grant_id;
   logic        err_timeout;

   int n_cmp = 0;
   int n_err = 0;

   com_arb #(.NREQ(4), .GID_W(2), .TO_W(4)) dut (
      .clk           (clk),
      .rst           (rst),
      .req_fs        (req_fs),
      .req_btype     (req_btype),
      .req_dlen      (req_dlen),
      .req_addr      (req_addr),
      .req_fd        (req_fd),
      .fs_send       (fs_send),
      .send_btype    (send_btype),
      .send_dlen     (send_dlen),
      .ram_addr_init (ram_addr_init),
      .fd_send       (fd_send),
      .busy          (busy),
      .grant_id      (grant_id),
      .err_timeout   (err_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic set_desc(input int r, input logic [3:0] bt, input logic [11:0] dl,
                           input logic [11:0] ad);
      req_btype[r*4 +: 4]  = bt;
      req_dlen[r*12 +: 12] = dl;
      req_addr[r*12 +: 12] = ad;
   endtask

   // Called at a negedge in IDLE with requests already applied; returns at a negedge back in IDLE.
   task automatic serve(input int gid, input logic [3:0] bt, input logic [11:0] dl,
                        input logic [11:0] ad, input int dly, input bit exp_fs, input bit rearm);
      logic [3:0] fd_mask;
      fd_mask = 4'b0001 << gid;
      @(negedge clk);
      chk("grant_id", 32'(grant_id), 32'(gid));
      chk("busy_grant", 32'(busy), 32'd1);
      chk("fs_in_grant", 32'(fs_send), 32'd0);
      @(negedge clk);
      chk("send_btype", 32'(send_btype), 32'(bt));
      chk("send_dlen", 32'(send_dlen), 32'(dl));
      chk("ram_addr_init", 32'(ram_addr_init), 32'(ad));
      chk("err_timeout", 32'(err_timeout), 32'd0);
      chk("fs_send", 32'(fs_send), 32'(exp_fs));
      if (exp_fs) begin
         chk("req_fd_in_send", 32'(req_fd), 32'd0);
         for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            chk("fs_hold", 32'(fs_send), 32'd1);
         end
         fd_send = 1'b1;
         @(negedge clk);
         chk("fs_drop", 32'(fs_send), 32'd0);
         chk("req_fd_done", 32'(req_fd), 32'(fd_mask));
         fd_send = 1'b0;
         @(negedge clk);
         chk("req_fd_hold", 32'(req_fd), 32'(fd_mask));
      end else begin
         chk("req_fd_zero_len", 32'(req_fd), 32'(fd_mask));
      end
      req_fs[gid] = 1'b0;
      @(negedge clk);
      chk("req_fd_clear", 32'(req_fd), 32'd0);
      chk("busy_idle", 32'(busy), 32'd0);
      chk("desc_hold", 32'({send_btype, send_dlen, ram_addr_init}), 32'({bt, dl, ad}));
      if (rearm) req_fs[gid] = 1'b1;
      $display("xfer gid=%0d btype=%h dlen=%0d addr=%h fs=%0d", gid, bt, dl, ad, exp_fs);
   endtask

   typedef struct {
      int         r;
      logic [3:0] bt;
      logic [11:0] dl;
      logic [11:0] ad;
      int         dly;
      int         exp_gid;
      bit         exp_fs;
   } vec_t;

   vec_t vecs[4];
   int   rr_exp[5];

   initial begin
      vecs[0] = '{r: 1, bt: 4'h3, dl: 12'd64,  ad: 12'h100, dly: 2, exp_gid: 1, exp_fs: 1'b1};
      vecs[1] = '{r: 2, bt: 4'h5, dl: 12'd0,   ad: 12'h200, dly: 0, exp_gid: 2, exp_fs: 1'b0};
      vecs[2] = '{r: 0, bt: 4'hA, dl: 12'd1,   ad: 12'hFFF, dly: 0, exp_gid: 0, exp_fs: 1'b1};
      vecs[3] = '{r: 3, bt: 4'hF, dl: 12'hFFF, ad: 12'h000, dly: 3, exp_gid: 3, exp_fs: 1'b1};
      rr_exp  = '{0, 1, 2, 3, 0};

      rst = 1'b0;
      req_fs = '0;
      req_btype = '0;
      req_dlen = '0;
      req_addr = '0;
      fd_send = 1'b0;

      repeat (2) @(negedge clk);
      chk("rst_outputs", 32'({req_fd, fs_send, busy, grant_id, err_timeout}), 32'd0);
      chk("rst_desc", 32'({send_btype, send_dlen, ram_addr_init}), 32'd0);
      rst = 1'b1;
      @(negedge clk);

      // Stray fd_send in IDLE must be ignored.
      fd_send = 1'b1;
      @(negedge clk);
      chk("idle_fd_ignored", 32'({busy, req_fd}), 32'd0);
      fd_send = 1'b0;

      for (int v = 0; v < 4; v++) begin
         set_desc(vecs[v].r, vecs[v].bt, vecs[v].dl, vecs[v].ad);
         req_fs[vecs[v].r] = 1'b1;
         serve(vecs[v].exp_gid, vecs[v].bt, vecs[v].dl, vecs[v].ad, vecs[v].dly,
               vecs[v].exp_fs, 1'b0);
      end

      // Round-robin with all four held; rr_ptr is 0 after requester 3.
      for (int i = 0; i < 4; i++) set_desc(i, 4'(i + 8), 12'(16 + i), 12'(12'h040 * i));
      req_fs = 4'b1111;
      for (int t = 0; t < 5; t++) begin
         serve(rr_exp[t], 4'(rr_exp[t] + 8), 12'(16 + rr_exp[t]), 12'(12'h040 * rr_exp[t]),
               1, 1'b1, 1'b1);
      end
      req_fs = '0;
      @(negedge clk);

      // Late request: rr_ptr=1, requester 0 alone, then 3 arrives during SEND.
      set_desc(0, 4'h7, 12'd20, 12'h050);
      set_desc(3, 4'hC, 12'd33, 12'h333);
      req_fs[0] = 1'b1;
      @(negedge clk);
      chk("late_grant0", 32'(grant_id), 32'd0);
      @(negedge clk);
      chk("late_fs", 32'(fs_send), 32'd1);
      req_fs[3] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("late_desc_stable", 32'({send_btype, send_dlen, ram_addr_init}),
             32'({4'h7, 12'd20, 12'h050}));
         chk("late_gid_stable", 32'(grant_id), 32'd0);
      end
      fd_send = 1'b1;
      @(negedge clk);
      chk("late_fd0", 32'(req_fd), 32'b0001);
      fd_send = 1'b0;
      req_fs[0] = 1'b0;
      @(negedge clk);
      chk("late_idle", 32'(busy), 32'd0);
      req_fs[0] = 1'b1;
      $display("xfer gid=0 btype=7 dlen=20 addr=050 fs=1 (late request pending)");
      serve(3, 4'hC, 12'd33, 12'h333, 1, 1'b1, 1'b0);
      serve(0, 4'h7, 12'd20, 12'h050, 0, 1'b1, 1'b0);

      // Reset mid-SEND; rr_ptr=1 beforehand, so 0-vs-3 pick reveals the reset pointer.
      set_desc(1, 4'h2, 12'd5, 12'h011);
      req_fs[1] = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("pre_rst_fs", 32'(fs_send), 32'd1);
      #2 rst = 1'b0;
      #1;
      chk("async_rst_outputs", 32'({req_fd, fs_send, busy, grant_id, err_timeout}), 32'd0);
      chk("async_rst_desc", 32'({send_btype, send_dlen, ram_addr_init}), 32'd0);
      req_fs = '0;
      @(negedge clk);
      rst = 1'b1;
      req_fs = 4'b1001;
      $display("xfer reset mid-send applied");
      serve(0, 4'h7, 12'd20, 12'h050, 0, 1'b1, 1'b0);
      serve(3, 4'hC, 12'd33, 12'h333, 0, 1'b1, 1'b0);

`ifdef COM_ARB_TIMEOUT_EN
      set_desc(2, 4'h1, 12'd9, 12'h0A0);
      req_fs[2] = 1'b1;
      @(negedge clk);
      chk("to_grant", 32'(grant_id), 32'd2);
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         chk("to_fs_hold", 32'({fs_send, err_timeout}), 32'b10);
      end
      @(negedge clk);
      chk("to_abort", 32'({fs_send, err_timeout, req_fd}), 32'b0_1_0100);
      fd_send = 1'b1;
      @(negedge clk);
      chk("to_pulse_once", 32'({err_timeout, req_fd}), 32'b0_0100);
      req_fs[2] = 1'b0;
      @(negedge clk);
      chk("to_exit_ignores_fd", 32'({busy, req_fd}), 32'd0);
      fd_send = 1'b0;
      $display("xfer gid=2 watchdog abort");
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
